// File: rtl/qrisc32_id_pkg.sv
// risc_pack: qrisc32 opcode map, decode bundle type and instruction field helpers
package risc_pack;
   localparam logic [5:0] OP_NOP      = 6'd0;
   localparam logic [5:0] OP_ALU_R_LO = 6'd1;
   localparam logic [5:0] OP_ALU_R_HI = 6'd15;
   localparam logic [5:0] OP_ALU_I_LO = 6'd16;
   localparam logic [5:0] OP_ALU_I_HI = 6'd31;
   localparam logic [5:0] OP_LDR      = 6'd32;
   localparam logic [5:0] OP_STR      = 6'd33;
   localparam logic [5:0] OP_JMP      = 6'd40;
   localparam logic [5:0] OP_JZ       = 6'd41;

   typedef struct packed {
      logic        valid;
      logic [5:0]  opcode;
      logic [4:0]  dst;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] store_data;
      logic        is_load;
      logic        is_store;
      logic        is_jump;
      logic        wr_en;
      logic [31:0] pc;
   } decoded_t;

   function automatic logic [5:0] f_op(input logic [31:0] i);
      return i[31:26];
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] i);
      return i[25:21];
   endfunction

   function automatic logic [4:0] f_rs1(input logic [31:0] i);
      return i[20:16];
   endfunction

   function automatic logic [4:0] f_rs2(input logic [31:0] i);
      return i[15:11];
   endfunction

   function automatic logic [31:0] f_imm(input logic [31:0] i);
      return {{16{i[15]}}, i[15:0]};
   endfunction
endpackage

// File: rtl/qrisc32_id_if.sv
// qrisc32_id_if: fetch, write-back and decode-bundle signals of the decode stage
interface qrisc32_id_if;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        pipe_stall;
   logic        new_address_valid;
   logic        wb_we;
   logic [4:0]  wb_dst;
   logic [31:0] wb_data;
   logic        id_stall_req;
   logic        id_valid;
   logic [5:0]  id_opcode;
   logic [4:0]  id_dst;
   logic [31:0] id_op1;
   logic [31:0] id_op2;
   logic [31:0] id_store_data;
   logic        id_is_load;
   logic        id_is_store;
   logic        id_is_jump;
   logic        id_wr_en;
   logic [31:0] id_pc;

   modport master (
      output instruction, pc, pipe_stall, new_address_valid, wb_we, wb_dst, wb_data,
      input  id_stall_req, id_valid, id_opcode, id_dst, id_op1, id_op2, id_store_data,
             id_is_load, id_is_store, id_is_jump, id_wr_en, id_pc
   );

   modport slave (
      input  instruction, pc, pipe_stall, new_address_valid, wb_we, wb_dst, wb_data,
      output id_stall_req, id_valid, id_opcode, id_dst, id_op1, id_op2, id_store_data,
             id_is_load, id_is_store, id_is_jump, id_wr_en, id_pc
   );
endinterface

// File: rtl/qrisc32_regfile.sv
// qrisc32_regfile: general registers, three combinational read ports with write-through bypass
module qrisc32_regfile #(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic [4:0]  rs1_idx,
   input  logic [4:0]  rs2_idx,
   input  logic [4:0]  rd_idx,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   output logic [31:0] rd_data,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   localparam int AW = $clog2(NREGS);

   logic [31:0] regs [NREGS];

   // write port; contents deliberately survive reset
   always_ff @(posedge clk)
      if (we) regs[wa[AW-1:0]] <= wd;

   assign rs1_data = (we && wa == rs1_idx) ? wd : regs[rs1_idx[AW-1:0]];
   assign rs2_data = (we && wa == rs2_idx) ? wd : regs[rs2_idx[AW-1:0]];
   assign rd_data  = (we && wa == rd_idx)  ? wd : regs[rd_idx[AW-1:0]];
endmodule

// File: rtl/qrisc32_id.sv
// qrisc32_id: decode stage with register file, load-use interlock and jump flush
module qrisc32_id
   import risc_pack::*;
#(
   parameter int          NREGS    = 32,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic         clk,
   input logic         reset,
   qrisc32_id_if.slave bus
);
   decoded_t    q, d, bub;
   logic        flush_pending, hold_v, stall_req, hazard;
   logic [31:0] hold_instr, hold_pc, src_instr, src_pc;
   logic [31:0] rs1_data, rs2_data, rd_data;
   logic [5:0]  op;
   logic [4:0]  rd, rs1, rs2;
   logic        is_alu_r, is_alu_i, is_ldr, is_str, is_jmp, is_jz;
   logic        use_imm, uses_rs1, uses_rs2, uses_rd;

   // a held (interlocked) instruction takes precedence over the fetch input
   assign src_instr = hold_v ? hold_instr : bus.instruction;
   assign src_pc    = hold_v ? hold_pc : bus.pc;
   assign op        = f_op(src_instr);
   assign rd        = f_rd(src_instr);
   assign rs1       = f_rs1(src_instr);
   assign rs2       = f_rs2(src_instr);
   assign is_alu_r  = op >= OP_ALU_R_LO && op <= OP_ALU_R_HI;
   assign is_alu_i  = op >= OP_ALU_I_LO && op <= OP_ALU_I_HI;
   assign is_ldr    = op == OP_LDR;
   assign is_str    = op == OP_STR;
   assign is_jmp    = op == OP_JMP;
   assign is_jz     = op == OP_JZ;
   assign use_imm   = is_alu_i | is_ldr | is_str | is_jmp | is_jz;
   assign uses_rs1  = is_alu_r | use_imm;
   assign uses_rs2  = is_alu_r;
   assign uses_rd   = is_str | is_jz;

   qrisc32_regfile #(.NREGS(NREGS)) u_rf (
      .clk      (clk),
      .rs1_idx  (rs1),
      .rs2_idx  (rs2),
      .rd_idx   (rd),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_data  (rd_data),
      .we       (bus.wb_we),
      .wa       (bus.wb_dst),
      .wd       (bus.wb_data)
   );

   // next bundle for a real instruction and for a bubble
   always_comb begin
      d            = '0;
      d.valid      = 1'b1;
      d.opcode     = op;
      d.dst        = rd;
      d.op1        = rs1_data;
      d.op2        = use_imm ? f_imm(src_instr) : rs2_data;
      d.store_data = rd_data;
      d.is_load    = is_ldr;
      d.is_store   = is_str;
      d.is_jump    = is_jmp | is_jz;
      d.wr_en      = is_alu_r | is_alu_i | is_ldr;
      d.pc         = src_pc;
      bub          = '0;
      bub.pc       = src_pc;
   end

   assign hazard = q.valid & q.is_load & ((uses_rs1 & rs1 == q.dst) |
                   (uses_rs2 & rs2 == q.dst) | (uses_rd & rd == q.dst));
   assign stall_req        = hazard & ~flush_pending & ~bus.new_address_valid;
   assign bus.id_stall_req = stall_req;

   // bundle register: flushes and interlocks insert bubbles, pipe_stall freezes everything
   always_ff @(posedge clk)
      if (reset) begin
         q             <= '0;
         q.pc          <= RESET_PC;
         flush_pending <= 1'b0;
         hold_v        <= 1'b0;
      end else if (!bus.pipe_stall) begin
         q             <= (bus.new_address_valid | flush_pending | stall_req) ? bub : d;
         flush_pending <= bus.new_address_valid;
         hold_v        <= stall_req;
         hold_instr    <= bus.instruction;
         hold_pc       <= bus.pc;
      end

   assign bus.id_valid      = q.valid;
   assign bus.id_opcode     = q.opcode;
   assign bus.id_dst        = q.dst;
   assign bus.id_op1        = q.op1;
   assign bus.id_op2        = q.op2;
   assign bus.id_store_data = q.store_data;
   assign bus.id_is_load    = q.is_load;
   assign bus.id_is_store   = q.is_store;
   assign bus.id_is_jump    = q.is_jump;
   assign bus.id_wr_en      = q.wr_en;
   assign bus.id_pc         = q.pc;
endmodule

// File: doc/qrisc32_id.md
Name: qrisc32_id

Overview:
- Decode stage of the qrisc32 5-stage pipeline, directly downstream of instruction fetch. Registers each fetched instruction and its PC, and decodes fields.
- Owns the 32x32 general register file: reads operands and accepts the write-back port from the MEM/WB side.
- Detects load-use hazards and squashes wrong-path instructions after a taken jump.
- Presents one registered decode bundle per cycle to EX.

Parameters:
- NREGS, 32, number of general registers; must be a power of two, index width clog2(NREGS).
- RESET_PC, 32'h0, value of id_pc after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instruction  in  32  instruction word from fetch
- pc  in  32  address of instruction
- pipe_stall  in  1  MEM-stage stall; freezes ID
- new_address_valid  in  1  taken jump/branch from EX (flush)
- wb_we  in  1  register write enable
- wb_dst  in  5  write register index
- wb_data  in  32  write data
- id_stall_req  out  1  load-use stall request, ORed into fetch pipe_stall by top level
- id_valid  out  1  bundle valid; 0 = bubble
- id_opcode  out  6  instruction[31:26]
- id_dst  out  5  instruction[25:21]
- id_op1  out  32  value of R[rs1]
- id_op2  out  32  R[rs2], or sign-extended imm16 when use_imm
- id_store_data  out  32  R[rd] for STR
- id_is_load, id_is_store, id_is_jump, id_wr_en  out  1 each  class flags
- id_pc  out  32  PC of the decoded instruction

Behaviour:
- Format: op[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm16[15:0].
- Opcode classes:
  - 0 = NOP (all-zero word).
  - 1–15 = ALU register form.
  - 16–31 = ALU immediate form (use_imm=1).
  - 32 = LDR (rd <- mem[rs1+imm]).
  - 33 = STR (mem[rs1+imm] <- rd).
  - 40 = JMP (target rs1+imm).
  - 41 = JZ (taken when R[rd]==0).
  - All other opcodes decode as NOP.
- id_wr_en = 1 for ALU and LDR classes only.
- Latency: one cycle. Inputs sampled at posedge clk appear on id_* after that edge.
- Register file:
  - Written at posedge when wb_we=1.
  - Reads are combinational with write-through bypass: if wb_we and wb_dst equals the read index in the same cycle, wb_data is used.
  - All registers are writable. R0 holds no special value.
  - The register file is not cleared by reset.
- Reset: id_valid=0, id_opcode=0, id_dst=0, id_op1=0, id_op2=0, id_store_data=0, all flags 0, id_pc=RESET_PC, id_stall_req=0, flush_pending=0, load_hold=0.
- pipe_stall=1: all id_* registers and internal state hold. id_stall_req is still computed. A write-back is still performed.
- Flush (new_address_valid=1, pipe_stall=0):
  - Next-cycle output is a bubble (id_valid=0, flags 0).
  - flush_pending is set, so the instruction presented on the following cycle, which is already fetched on the wrong path, also becomes a bubble. flush_pending then clears.
  - Flush has priority over load-use stall and clears load_hold.
- Load-use: if the registered bundle is valid, id_is_load=1, and id_dst matches a source actually used by the current instruction (rs1; rs2 when register form; rd for STR/JZ):
  - id_stall_req=1 combinationally.
  - The next output is a bubble and the current instruction is retained in a one-entry hold register (load_hold).
  - The next cycle re-decodes from the hold register, with operands re-read, and deasserts the stall. The stall lasts exactly one cycle per hazard.
- A NOP with flush_pending=0 produces id_valid=1, opcode 0, and all flags 0.
- Reset asserted mid-stall or mid-flush returns to the reset state on the next edge. A pending hold is discarded.

Decomposition:
- risc_pack holds:
  - The opcode localparams (OP_NOP, OP_LDR, OP_STR, OP_JMP, OP_JZ, ALU ranges).
  - A packed struct decoded_t for the output bundle.
  - Field-slice helper functions.
- One sub-module, qrisc32_regfile: NREGS x 32, two read ports plus a store-data port, one write port, bypass inside.
- Decode, hazard and flush logic stay in qrisc32_id.

Test Plan:
- Reset, then instruction=0, pc=0 → after the first edge id_valid=1, id_opcode=0, id_wr_en=0, id_pc=0.
- Write R3=32'h1234 via wb, then ADD-imm op=16, rd=4, rs1=3, imm=16'hFFFF → id_op1=32'h1234, id_op2=32'hFFFFFFFF, id_wr_en=1.
- Same-cycle wb_we, wb_dst=5, wb_data=32'hA5A5A5A5 while decoding rs1=5 → id_op1=32'hA5A5A5A5, not the stale value.
- LDR rd=7 followed by an ALU op with rs2=7 → id_stall_req=1 for one cycle, one bubble, then the ALU op is decoded with id_valid=1 and correct PC.
- new_address_valid pulse for one cycle with instructions I1, I2 streaming in → two consecutive id_valid=0 cycles; the first post-jump instruction is decoded valid.
- pipe_stall held 3 cycles with a changing input instruction → all id_* outputs are unchanged throughout; decode resumes on the first unstalled edge.
